// File: rtl/vec_alu_pkg.sv
// Shared definitions for the vector execute unit and the decoder feeding it:
// ALUControl codes, FSM states and NZCV bit positions.
package vec_alu_pkg;

    localparam logic [2:0] OP_VADD = 3'b000;
    localparam logic [2:0] OP_VSUB = 3'b001;
    localparam logic [2:0] OP_VAND = 3'b010;
    localparam logic [2:0] OP_VOR  = 3'b011;
    localparam logic [2:0] OP_VXOR = 3'b100;
    localparam logic [2:0] OP_VMUL = 3'b110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op != 3'b101) && (op != 3'b111);
    endfunction

endpackage

// File: rtl/vec_lane_addsub.sv
// One lane of the packed adder: a + b, or a + ~b + 1 for subtract, with the
// lane's carry-out and signed overflow.
module vec_lane_addsub #(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    input  logic              sub_i,
    output logic [LANE_W-1:0] sum_o,
    output logic              carry_o,
    output logic              ovf_o
);

    logic [LANE_W-1:0] b_eff;
    logic [LANE_W:0]   full;

    assign b_eff   = sub_i ? ~b_i : b_i;
    assign full    = {1'b0, a_i} + {1'b0, b_eff} + {{LANE_W{1'b0}}, sub_i};
    assign sum_o   = full[LANE_W-1:0];
    assign carry_o = full[LANE_W];
    // Overflow when both addends share a sign that the sum does not.
    assign ovf_o   = (a_i[LANE_W-1] == b_eff[LANE_W-1]) && (sum_o[LANE_W-1] != a_i[LANE_W-1]);

endmodule

// File: rtl/vec_alu_seq.sv
// Sequential packed-lane execute unit: single-cycle add/sub/logic/move and an
// iterative per-lane shift-add multiply, behind a start/busy/done handshake.
module vec_alu_seq
    import vec_alu_pkg::*;
#(
    parameter  int LANES  = 4,
    parameter  int LANE_W = 8,
    localparam int W      = LANES * LANE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   ALUControl,
    input  logic         mov,
    input  logic [W-1:0] SrcA,
    input  logic [W-1:0] SrcB,
    output logic         busy,
    output logic         done,
    output logic         illegal,
    output logic [W-1:0] Result,
    output logic [3:0]   ALUFlags
);

    localparam int CNT_W = (LANE_W > 1) ? $clog2(LANE_W) : 1;

    state_e           state_q, state_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             illegal_q, illegal_d;

    logic [W-1:0]     addsub_res, alu_res;
    logic [W-1:0]     acc_step, mcand_step, mplier_step;
    logic [LANES-1:0] lane_c, lane_v;
    logic             use_cv;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        vec_lane_addsub #(.LANE_W(LANE_W)) u_addsub (
            .a_i     (SrcA[l*LANE_W +: LANE_W]),
            .b_i     (SrcB[l*LANE_W +: LANE_W]),
            .sub_i   (ALUControl == OP_VSUB),
            .sum_o   (addsub_res[l*LANE_W +: LANE_W]),
            .carry_o (lane_c[l]),
            .ovf_o   (lane_v[l])
        );
    end

    assign use_cv = (ALUControl == OP_VSUB) || ((ALUControl == OP_VADD) && !mov);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        alu_res = '0;
        case (ALUControl)
            OP_VADD: alu_res = mov ? SrcB : addsub_res;
            OP_VSUB: alu_res = addsub_res;
            OP_VAND: alu_res = SrcA & SrcB;
            OP_VOR:  alu_res = SrcA | SrcB;
            OP_VXOR: alu_res = SrcA ^ SrcB;
            default: alu_res = '0;
        endcase
    end

    // One shift-add step per lane; shifts stay inside each lane.
    always_comb begin
        acc_step    = '0;
        mcand_step  = '0;
        mplier_step = '0;
        for (int l = 0; l < LANES; l++) begin
            acc_step[l*LANE_W +: LANE_W]    = acc_q[l*LANE_W +: LANE_W]
                                            + (mplier_q[l*LANE_W] ? mcand_q[l*LANE_W +: LANE_W] : '0);
            mcand_step[l*LANE_W +: LANE_W]  = mcand_q[l*LANE_W +: LANE_W] << 1;
            mplier_step[l*LANE_W +: LANE_W] = mplier_q[l*LANE_W +: LANE_W] >> 1;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_MUL: begin
                mcand_d  = mcand_step;
                mplier_d = mplier_step;
                acc_d    = acc_step;
                if (cnt_q == '0) begin
                    result_d         = acc_step;
                    flags_d          = '0;
                    flags_d[FLAG_N]  = acc_step[W-1];
                    flags_d[FLAG_Z]  = (acc_step == '0);
                    state_d          = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (start) begin
                    illegal_d = !op_is_legal(ALUControl);
                    if (ALUControl == OP_VMUL) begin
                        mcand_d  = SrcA;
                        mplier_d = SrcB;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(LANE_W - 1);
                        state_d  = ST_MUL;
                    end else begin
                        result_d        = illegal_d ? '0 : alu_res;
                        flags_d         = '0;
                        flags_d[FLAG_N] = result_d[W-1];
                        flags_d[FLAG_Z] = (result_d == '0);
                        flags_d[FLAG_C] = use_cv & lane_c[LANES-1];
                        flags_d[FLAG_V] = use_cv & lane_v[LANES-1];
                        state_d         = ST_DONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy     = (state_q == ST_MUL);
    assign done     = (state_q == ST_DONE);
    assign illegal  = done & illegal_q;
    assign Result   = result_q;
    assign ALUFlags = flags_q;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Self-checking bench for vec_alu_seq: directed vector table, hand-written
// handshake/reset sequences, and random ops against a lane-arithmetic model.
module tb_vec_alu_seq;
    import vec_alu_pkg::*;

    localparam int LW = 8;
    localparam int NL = 4;
    localparam int M  = 1 << LW;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  ALUControl = 3'b000;
    logic        mov = 1'b0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        busy, done, illegal;
    logic [31:0] Result;
    logic [3:0]  ALUFlags;

    int checks = 0;
    int errors = 0;

    vec_alu_seq #(.LANES(NL), .LANE_W(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ALUControl (ALUControl),
        .mov        (mov),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal),
        .Result     (Result),
        .ALUFlags   (ALUFlags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flags;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [2:0]  op;
        logic        mv;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
        logic        ill;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane-by-lane integer arithmetic from the op definitions.
    function automatic exp_t model(input logic [2:0] op, input logic mv,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int ua, ub, sa, sb, r, s, rm;
        e = '0;
        if (op == 3'b101 || op == 3'b111) begin
            e.flags = 4'b0100;
            e.ill   = 1'b1;
            return e;
        end
        for (int l = 0; l < NL; l++) begin
            ua = int'(a[l*LW +: LW]);
            ub = int'(b[l*LW +: LW]);
            sa = (ua >= M / 2) ? ua - M : ua;
            sb = (ub >= M / 2) ? ub - M : ub;
            r = 0;
            s = 0;
            case (op)
                OP_VADD: begin r = mv ? ub : ua + ub; s = sa + sb; end
                OP_VSUB: begin r = ua - ub; s = sa - sb; end
                OP_VAND: r = ua & ub;
                OP_VOR:  r = ua | ub;
                OP_VXOR: r = ua ^ ub;
                default: r = ua * ub;
            endcase
            rm = ((r % M) + M) % M;
            e.res[l*LW +: LW] = rm[LW-1:0];
            if (l == NL - 1 && (op == OP_VSUB || (op == OP_VADD && !mv))) begin
                e.flags[1] = (op == OP_VADD) ? (ua + ub >= M) : (ua >= ub);
                e.flags[0] = (s < -(M / 2)) || (s >= M / 2);
            end
        end
        e.flags[3] = e.res[31];
        e.flags[2] = (e.res == 32'h0);
        return e;
    endfunction

    // Issue one op right after a negedge and wait (bounded) for done.
    // lat counts edges after the accepting edge until done is seen.
    task automatic run_op(input logic [2:0] op, input logic mv, input logic [31:0] a,
                          input logic [31:0] b, input bit poke,
                          output logic [31:0] res, output logic [3:0] fl,
                          output logic ill, output int lat);
        ALUControl = op;
        mov        = mv;
        SrcA       = a;
        SrcB       = b;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        check("busy_after_accept", busy, op == OP_VMUL);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 3) begin
                start      = 1'b1;
                ALUControl = OP_VADD;
                SrcA       = $urandom;
                SrcB       = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        check("busy_with_done", busy, 1'b0);
        res = Result;
        fl  = ALUFlags;
        ill = illegal;
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("result_held", Result, res);
    endtask

    vec_t        vecs[12];
    exp_t        e;
    logic [31:0] r_res;
    logic [3:0]  r_fl;
    logic        r_ill;
    int          r_lat;
    logic [2:0]  rop;
    logic        rmv;
    logic [31:0] ra, rb;

    initial begin
        vecs[0]  = '{OP_VADD, 1'b0, 32'h01FF7F10, 32'h01017F10, 32'h0200FE20, 4'b0000, 1'b0};
        vecs[1]  = '{OP_VSUB, 1'b0, 32'h00000005, 32'h00000006, 32'h000000FF, 4'b0010, 1'b0};
        vecs[2]  = '{OP_VMUL, 1'b0, 32'h03FF1002, 32'h05020304, 32'h0FFE3008, 4'b0000, 1'b0};
        vecs[3]  = '{OP_VADD, 1'b1, 32'h12345678, 32'h80000000, 32'h80000000, 4'b1000, 1'b0};
        vecs[4]  = '{OP_VAND, 1'b0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b0100, 1'b0};
        vecs[5]  = '{3'b101,  1'b0, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 4'b0100, 1'b1};
        vecs[6]  = '{3'b111,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100, 1'b1};
        vecs[7]  = '{OP_VADD, 1'b0, 32'h7F000000, 32'h01000000, 32'h80000000, 4'b1001, 1'b0};
        vecs[8]  = '{OP_VADD, 1'b0, 32'hFF000000, 32'h01000000, 32'h00000000, 4'b0110, 1'b0};
        vecs[9]  = '{OP_VOR,  1'b0, 32'h12340000, 32'h00005678, 32'h12345678, 4'b0000, 1'b0};
        vecs[10] = '{OP_VXOR, 1'b0, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hF0F0F0F0, 4'b1000, 1'b0};
        vecs[11] = '{OP_VSUB, 1'b0, 32'h80000000, 32'h01000000, 32'h7F000000, 4'b0011, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_result", Result, 32'h0);
        check("rst_flags", ALUFlags, 4'h0);
        reset = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].mv, vecs[i].a, vecs[i].b, 1'b0, r_res, r_fl, r_ill, r_lat);
            check($sformatf("vec%0d_result", i), r_res, vecs[i].res);
            check($sformatf("vec%0d_flags", i), r_fl, vecs[i].flags);
            check($sformatf("vec%0d_illegal", i), r_ill, vecs[i].ill);
            check($sformatf("vec%0d_latency", i), r_lat, (vecs[i].op == OP_VMUL) ? LW : 0);
        end

        // VMUL with a start pulse and operand changes while busy
        run_op(OP_VMUL, 1'b0, 32'h03FF1002, 32'h05020304, 1'b1, r_res, r_fl, r_ill, r_lat);
        check("mul_poke_result", r_res, 32'h0FFE3008);
        check("mul_poke_latency", r_lat, LW);

        // MOV then back-to-back VAND issued in DONE
        ALUControl = OP_VADD; mov = 1'b1; SrcA = 32'h12345678; SrcB = 32'h80000000; start = 1'b1;
        @(negedge clk);
        check("b2b_mov_done", done, 1'b1);
        check("b2b_mov_result", Result, 32'h80000000);
        check("b2b_mov_flags", ALUFlags, 4'b1000);
        ALUControl = OP_VAND; mov = 1'b0; SrcA = 32'hF0F0F0F0; SrcB = 32'h0F0F0F0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_and_done", done, 1'b1);
        check("b2b_and_result", Result, 32'h0);
        check("b2b_and_flags", ALUFlags, 4'b0100);
        @(negedge clk);
        check("b2b_and_done_drop", done, 1'b0);

        // Reset during VMUL iteration
        run_op(OP_VADD, 1'b0, 32'h01FF7F10, 32'h01017F10, 1'b0, r_res, r_fl, r_ill, r_lat);
        ALUControl = OP_VMUL; SrcA = 32'h03FF1002; SrcB = 32'h05020304; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_mul_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_result", Result, 32'h0);
        check("rst_mid_flags", ALUFlags, 4'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_no_done", done, 1'b0);
        run_op(OP_VADD, 1'b0, 32'h01FF7F10, 32'h01017F10, 1'b0, r_res, r_fl, r_ill, r_lat);
        check("post_rst_vadd_result", r_res, 32'h0200FE20);
        check("post_rst_vadd_latency", r_lat, 0);

        // Random ops against the model
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            rmv = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            e   = model(rop, rmv, ra, rb);
            run_op(rop, rmv, ra, rb, 1'b0, r_res, r_fl, r_ill, r_lat);
            check($sformatf("rnd%0d_result", i), r_res, e.res);
            check($sformatf("rnd%0d_flags", i), r_fl, e.flags);
            check($sformatf("rnd%0d_illegal", i), r_ill, e.ill);
            check($sformatf("rnd%0d_latency", i), r_lat, (rop == OP_VMUL) ? LW : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_alu_seq.md
# vec_alu_seq

Sequential vector execute unit: the consumer of the instruction decoder's `ALUControl`/`mov` encoding. It executes packed-lane VADD/VSUB/VAND/VOR/VXOR/MOV in one cycle and VMUL as an iterative per-lane shift-add over LANE_W cycles, then returns the result with NZCV flags on a start/busy/done handshake. It sits between the register-file read stage and writeback, and stalls the core while `busy` is high.

## Interface
- LANES, default 4: number of packed lanes.
- LANE_W, default 8: lane width in bits; word width W = LANES*LANE_W (32 by default).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when `busy`=0.
- ALUControl  in  3  op code: 000 VADD, 001 VSUB, 010 VAND, 011 VOR, 100 VXOR, 110 VMUL; 101 and 111 are illegal.
- mov  in  1  with ALUControl=000, selects MOV (Result=SrcB).
- SrcA, SrcB  in  W  operands; sampled only on an accepted start.
- busy  out  1  high while a VMUL iterates.
- done  out  1  one-cycle pulse; `Result`/`ALUFlags` valid and held until the next accepted start.
- illegal  out  1  pulses with `done` for codes 101/111.
- Result  out  W  packed lane result.
- ALUFlags  out  4  {N,Z,C,V}.

## Operation
- States: IDLE, MUL, DONE. Reset puts the unit in IDLE with busy=0, done=0, illegal=0, Result=0 and ALUFlags=0.
- start is accepted in IDLE or DONE (back-to-back allowed) and ignored in MUL. It is never queued.
- Single-cycle ops: on the accepting edge, the unit registers Result and flags and enters DONE.
- Lanes are independent. There is no carry or borrow between lanes, and every result wraps modulo 2^LANE_W.
- VSUB computes A + ~B + 1 per lane.
- MOV: Result=SrcB.
- VMUL, on the accepting edge:
  - load mcand=SrcA, mplier=SrcB, acc=0, cnt=LANE_W-1; enter MUL.
  - each MUL cycle, per lane: if mplier bit0 is set, acc+=mcand; then mcand<<=1 and mplier>>=1 (lane-local, truncated).
  - when cnt==0, write Result=acc and enter DONE; otherwise cnt--.
  - the result is the low LANE_W bits of each lane product.
- Illegal code: Result=0, flags {0,1,0,0}, illegal=1 with done.
- Flags:
  - N = Result[W-1]; Z = (Result==0).
  - C and V come from the top lane only, for VADD/VSUB (not MOV). C is the carry-out; for VSUB, C=1 means no borrow. V is signed overflow.
  - C=V=0 for all other ops.
- DONE returns to IDLE on the next edge unless a new start is accepted.

## Timing
- start at edge k, single-cycle op: done is high during cycle k→k+1.
- VMUL: busy is high from after edge k until edge k+LANE_W. done is high during cycle k+LANE_W→k+LANE_W+1. Latency is LANE_W cycles (8 by default).
- busy and done are never high in the same cycle.
- An accepted start in DONE drops done on that edge and starts the new op.
- Asserting reset mid-VMUL clears the unit immediately, with no done pulse. The first start after reset release is accepted normally.
- Operand changes while busy do not affect the result.

## Structure
- Shared package `vec_alu_pkg`: ALUControl code constants (VADD..VMUL), the state enum, and the flag bit positions. The decoder uses the same package.
- Sub-module `vec_lane_addsub` (LANE_W-bit add/sub producing carry and overflow), instantiated LANES times. The top-lane instance supplies C/V.
- The VMUL iteration, counter, and FSM live in the top module.

## Test plan
- VADD, A=0x01FF7F10, B=0x01017F10 -> Result=0x0200FE20, NZCV=0000, done 1 cycle after start.
- VSUB, A=0x00000005, B=0x00000006 -> Result=0x000000FF, NZCV=0010. Lane 0 wraps with no inter-lane borrow.
- VMUL, A=0x03FF1002, B=0x05020304 -> busy for 8 cycles, then Result=0x0FFE3008 with done at cycle 8. A start pulsed during busy is ignored.
- MOV (mov=1, ALUControl=000), SrcB=0x80000000 -> Result=0x80000000, NZCV=1000. Back-to-back VAND 0xF0F0F0F0 & 0x0F0F0F0F is issued in DONE -> Result=0, Z=1.
- ALUControl=101 -> Result=0, NZCV=0100, illegal and done pulse together.
- reset asserted at cycle 4 of a VMUL -> busy=0, done=0, Result=0 immediately. A following VADD completes normally.
